timer_share_sched: RTL and testbench

- Round-robin scheduler that time-shares one interval timer between N_REQ requesters.
- Each requester asks for a one-shot delay of a given period. The scheduler grants one requester and programs the timer over the timer's 16-bit register-slave port, acting as master.
- It waits for the timer irq, clears the timeout status, then pulses done to the granted requester.
- It sits between the requesting logic and the timer instance and is the timer's only register master.

---
 rtl/timer_share_sched_if.sv | 24 ++
 rtl/timer_share_sched.sv | 212 +++++++++++++++++++++
 tb/tb_timer_share_sched.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_share_sched_if.sv
// Register-slave bus between the scheduler (master) and the shared interval timer.
interface timer_share_sched_if;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic        tmr_irq;

    modport master (
        output tmr_address,
        output tmr_chipselect,
        output tmr_write_n,
        output tmr_writedata,
        input  tmr_irq
    );

    modport slave (
        input  tmr_address,
        input  tmr_chipselect,
        input  tmr_write_n,
        input  tmr_writedata,
        output tmr_irq
    );
endinterface

// File: rtl/timer_share_sched.sv
// Round-robin scheduler time-sharing one one-shot interval timer among N_REQ requesters.
// It is the timer's only register master; expiry is reported to the winner with a done pulse.
module timer_share_sched #(
    parameter int          N_REQ      = 4,
    parameter logic [15:0] STOP_WORD  = 16'h0008,
    parameter logic [15:0] START_WORD = 16'h0005
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  period,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic                 busy,
    timer_share_sched_if.master  tmr
);
    localparam int                IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0]  ONE_HOT0   = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [2:0]        A_STATUS   = 3'd0;
    localparam logic [2:0]        A_CONTROL  = 3'd1;
    localparam logic [2:0]        A_PERIOD_L = 3'd2;
    localparam logic [2:0]        A_PERIOD_H = 3'd3;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_STOP       = 4'd1,
        S_CLR0       = 4'd2,
        S_PL         = 4'd3,
        S_PH         = 4'd4,
        S_START      = 4'd5,
        S_WAIT       = 4'd6,
        S_CLR1       = 4'd7,
        S_DONE       = 4'd8,
        S_ABORT_STOP = 4'd9,
        S_ABORT_CLR  = 4'd10
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   winner_r;
    logic [IDX_W-1:0]   win_sel_s;
    logic [31:0]        period_r;
    logic [31:0]        period_sel_s;
    logic [31:0]        period_lat_s;
    logic [N_REQ-1:0]   grant_r;
    logic [N_REQ-1:0]   done_r;
    logic               busy_r;
    logic [2:0]         addr_r;
    logic [2:0]         addr_nxt_s;
    logic               cs_r;
    logic               cs_nxt_s;
    logic               wn_r;
    logic [15:0]        wdata_r;
    logic [15:0]        wdata_nxt_s;
    logic               held_s;

    // First requester at or after the pointer, wrapping modulo N_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = p;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(p) + k) % N_REQ;
            if (!found && r[idx[IDX_W-1:0]]) begin
                sel   = idx[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        int nxt;
        nxt = (int'(idx) + 1) % N_REQ;
        return nxt[IDX_W-1:0];
    endfunction

    // Winner selection and its period; a zero period is promoted to one.
    always_comb begin
        win_sel_s    = rr_pick(req, rr_ptr_r);
        period_sel_s = 32'd0;
        for (int i = 0; i < N_REQ; i++) begin
            period_sel_s = (IDX_W'(i) == win_sel_s) ? period[32*i +: 32] : period_sel_s;
        end
        period_lat_s = (period_sel_s == 32'd0) ? 32'd1 : period_sel_s;
        held_s       = req[winner_r];
    end

    // Next-state logic; a withdrawn request diverts to the abort writes after the current one.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:       state_nxt_s = (|req)  ? S_STOP  : S_IDLE;
            S_STOP:       state_nxt_s = held_s  ? S_CLR0  : S_ABORT_STOP;
            S_CLR0:       state_nxt_s = held_s  ? S_PL    : S_ABORT_STOP;
            S_PL:         state_nxt_s = held_s  ? S_PH    : S_ABORT_STOP;
            S_PH:         state_nxt_s = held_s  ? S_START : S_ABORT_STOP;
            S_START:      state_nxt_s = held_s  ? S_WAIT  : S_ABORT_STOP;
            S_WAIT: begin
                if (tmr.tmr_irq) begin
                    state_nxt_s = S_CLR1;
                end else if (!held_s) begin
                    state_nxt_s = S_ABORT_STOP;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_CLR1:       state_nxt_s = S_DONE;
            S_DONE:       state_nxt_s = S_IDLE;
            S_ABORT_STOP: state_nxt_s = S_ABORT_CLR;
            S_ABORT_CLR:  state_nxt_s = S_IDLE;
            default:      state_nxt_s = S_IDLE;
        endcase
    end

    // Timer bus values for the upcoming state, registered so the write lands in that state.
    always_comb begin
        cs_nxt_s    = 1'b0;
        addr_nxt_s  = A_STATUS;
        wdata_nxt_s = 16'h0000;
        case (state_nxt_s)
            S_STOP, S_ABORT_STOP: begin
                cs_nxt_s    = 1'b1;
                addr_nxt_s  = A_CONTROL;
                wdata_nxt_s = STOP_WORD;
            end
            S_CLR0, S_CLR1, S_ABORT_CLR: begin
                cs_nxt_s    = 1'b1;
                addr_nxt_s  = A_STATUS;
                wdata_nxt_s = 16'h0000;
            end
            S_PL: begin
                cs_nxt_s    = 1'b1;
                addr_nxt_s  = A_PERIOD_L;
                wdata_nxt_s = period_r[15:0];
            end
            S_PH: begin
                cs_nxt_s    = 1'b1;
                addr_nxt_s  = A_PERIOD_H;
                wdata_nxt_s = period_r[31:16];
            end
            S_START: begin
                cs_nxt_s    = 1'b1;
                addr_nxt_s  = A_CONTROL;
                wdata_nxt_s = START_WORD;
            end
            default: begin
                cs_nxt_s    = 1'b0;
                addr_nxt_s  = A_STATUS;
                wdata_nxt_s = 16'h0000;
            end
        endcase
    end

    // State register and timer bus registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            cs_r    <= 1'b0;
            wn_r    <= 1'b1;
            addr_r  <= 3'd0;
            wdata_r <= 16'h0000;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cs_r    <= cs_nxt_s;
            wn_r    <= ~cs_nxt_s;
            addr_r  <= addr_nxt_s;
            wdata_r <= wdata_nxt_s;
            busy_r  <= (state_nxt_s != S_IDLE);
        end
    end

    // Grant, latched period, done pulse and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_r  <= {N_REQ{1'b0}};
            done_r   <= {N_REQ{1'b0}};
            winner_r <= {IDX_W{1'b0}};
            rr_ptr_r <= {IDX_W{1'b0}};
            period_r <= 32'd0;
        end else begin
            done_r <= (state_nxt_s == S_DONE) ? (ONE_HOT0 << winner_r) : {N_REQ{1'b0}};
            if (state_r == S_IDLE && (|req)) begin
                grant_r  <= ONE_HOT0 << win_sel_s;
                winner_r <= win_sel_s;
                period_r <= period_lat_s;
            end else if (state_nxt_s == S_IDLE) begin
                grant_r  <= {N_REQ{1'b0}};
            end else begin
                grant_r  <= grant_r;
            end
            if (state_r == S_DONE || state_r == S_ABORT_CLR) begin
                rr_ptr_r <= rr_next(winner_r);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign grant              = grant_r;
    assign done               = done_r;
    assign busy               = busy_r;
    assign tmr.tmr_address    = addr_r;
    assign tmr.tmr_chipselect = cs_r;
    assign tmr.tmr_write_n    = wn_r;
    assign tmr.tmr_writedata  = wdata_r;
endmodule

// File: tb/tb_timer_share_sched.sv
// Scoreboard bench for timer_share_sched with a small one-shot timer model on the register bus.
module tb_timer_share_sched;
    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] period;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic         busy;

    timer_share_sched_if bus();

    timer_share_sched #(.N_REQ(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .period (period),
        .grant  (grant),
        .done   (done),
        .busy   (busy),
        .tmr    (bus)
    );

    always #5 clk = ~clk;

    // Timer model: not reset by the scheduler's reset.
    logic [31:0] m_per = 32'd0;
    logic [31:0] m_cnt = 32'd0;
    logic        m_run = 1'b0;
    logic        m_to  = 1'b0;
    logic        m_ito = 1'b0;
    assign bus.tmr_irq = m_to & m_ito;

    always @(posedge clk) begin
        if (bus.tmr_chipselect && !bus.tmr_write_n) begin
            case (bus.tmr_address)
                3'd0: m_to <= 1'b0;
                3'd1: begin
                    m_ito <= bus.tmr_writedata[0];
                    if (bus.tmr_writedata[3]) m_run <= 1'b0;
                    else if (bus.tmr_writedata[2]) begin
                        m_run <= 1'b1;
                        m_cnt <= m_per;
                    end
                end
                3'd2: m_per[15:0]  <= bus.tmr_writedata;
                3'd3: m_per[31:16] <= bus.tmr_writedata;
                default: m_to <= m_to;
            endcase
        end else if (m_run) begin
            if (m_cnt == 32'd0) begin
                m_to  <= 1'b1;
                m_run <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 32'd1;
            end
        end
    end

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
        logic [3:0]  g;
    } wr_t;

    wr_t        wq[$];
    logic [3:0] dq[$];
    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    int done_seen = 0;
    int cyc = 0;
    int irq_rise = -100;
    logic irq_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL timeout_%s wr_seen=%0d done_seen=%0d", name, wr_seen, done_seen);
    endtask

    // Monitor: pops expected writes/dones whenever the DUT presents them.
    initial begin
        wr_t        e;
        logic [3:0] ed;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (bus.tmr_irq && !irq_prev) irq_rise = cyc;
                irq_prev = bus.tmr_irq;
                check("grant_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
                check("write_n_vs_cs", {31'd0, bus.tmr_write_n}, {31'd0, ~bus.tmr_chipselect});
                if (bus.tmr_chipselect && !bus.tmr_write_n) begin
                    wr_seen++;
                    if (wq.size() == 0) begin
                        timeout_fail("unexpected_write");
                    end else begin
                        e = wq.pop_front();
                        check("wr_addr", {29'd0, bus.tmr_address}, {29'd0, e.a});
                        check("wr_data", {16'd0, bus.tmr_writedata}, {16'd0, e.d});
                        check("wr_grant", {28'd0, grant}, {28'd0, e.g});
                    end
                end
                if (done != 4'b0000) begin
                    done_seen++;
                    if (dq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual=0x%0h required=none", done);
                    end else begin
                        ed = dq.pop_front();
                        check("done_value", {28'd0, done}, {28'd0, ed});
                        check("irq_to_done_latency", cyc - irq_rise, 32'd2);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [15:0] d, input logic [3:0] g);
        wr_t e;
        e.a = a;
        e.d = d;
        e.g = g;
        wq.push_back(e);
    endtask

    task automatic push_head(input logic [3:0] g, input logic [15:0] pl, input logic [15:0] ph);
        push_wr(3'd1, 16'h0008, g);
        push_wr(3'd0, 16'h0000, g);
        push_wr(3'd2, pl, g);
        push_wr(3'd3, ph, g);
        push_wr(3'd1, 16'h0005, g);
    endtask

    task automatic push_service(input logic [3:0] g, input logic [15:0] pl, input logic [15:0] ph);
        push_head(g, pl, ph);
        push_wr(3'd0, 16'h0000, g);
        dq.push_back(g);
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int i = 0;
        while (wr_seen < n && i < budget) begin
            tick();
            i++;
        end
        if (wr_seen < n) timeout_fail(name);
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int i = 0;
        while (done_seen < n && i < budget) begin
            tick();
            i++;
        end
        if (done_seen < n) timeout_fail(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, {28'd0, grant}, 32'd0);
        check({tag, "_done"}, {28'd0, done}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_cs"}, {31'd0, bus.tmr_chipselect}, 32'd0);
        check({tag, "_write_n"}, {31'd0, bus.tmr_write_n}, 32'd1);
        check({tag, "_addr"}, {29'd0, bus.tmr_address}, 32'd0);
        check({tag, "_wdata"}, {16'd0, bus.tmr_writedata}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wb;
        int db;
        int i;
        reset  = 1'b1;
        req    = 4'b0000;
        period = 128'd0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Round robin 0,1,3,0,1,3 with req held.
        for (int k = 0; k < 4; k++) period[32*k +: 32] = 32'd5;
        db = done_seen;
        push_service(4'b0001, 16'h0005, 16'h0000);
        push_service(4'b0010, 16'h0005, 16'h0000);
        push_service(4'b1000, 16'h0005, 16'h0000);
        push_service(4'b0001, 16'h0005, 16'h0000);
        push_service(4'b0010, 16'h0005, 16'h0000);
        push_service(4'b1000, 16'h0005, 16'h0000);
        req = 4'b1011;
        wait_done(db + 6, 400, "round_robin");
        req = 4'b0000;
        repeat (3) tick();

        // Single request, period 10; first write one cycle after req is seen.
        period[31:0] = 32'd10;
        db = done_seen;
        push_service(4'b0001, 16'h000A, 16'h0000);
        req = 4'b0001;
        tick();
        check("first_write_latency", {28'd0, bus.tmr_chipselect, bus.tmr_address}, {28'd0, 1'b1, 3'd1});
        check("busy_in_service", {31'd0, busy}, 32'd1);
        wait_done(db + 1, 100, "single");
        req = 4'b0000;
        repeat (3) tick();

        // Period change during WAIT must not affect the service.
        period[63:32] = 32'd8;
        wb = wr_seen;
        db = done_seen;
        push_service(4'b0010, 16'h0008, 16'h0000);
        req = 4'b0010;
        wait_writes(wb + 5, 20, "change_head");
        repeat (2) tick();
        period[63:32] = 32'd1000;
        wait_done(db + 1, 60, "change_during_wait");
        req = 4'b0000;
        repeat (3) tick();

        // Split period, then withdrawal during WAIT.
        period[95:64] = 32'h0003_0001;
        wb = wr_seen;
        push_head(4'b0100, 16'h0001, 16'h0003);
        push_wr(3'd1, 16'h0008, 4'b0100);
        push_wr(3'd0, 16'h0000, 4'b0100);
        req = 4'b0100;
        wait_writes(wb + 5, 20, "split_head");
        repeat (5) tick();
        period[95:64] = 32'd2;
        req = 4'b0000;
        wait_writes(wb + 7, 20, "abort");
        tick();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_grant", {28'd0, grant}, 32'd0);

        // Pointer advanced past the withdrawn requester; zero period becomes one.
        period[127:96] = 32'd0;
        period[95:64]  = 32'd5;
        db = done_seen;
        push_service(4'b1000, 16'h0001, 16'h0000);
        req = 4'b1100;
        wait_done(db + 1, 60, "period_zero");
        req = 4'b0000;
        repeat (3) tick();

        // irq and req drop in the same WAIT cycle: irq wins.
        period[31:0] = 32'd6;
        wb = wr_seen;
        db = done_seen;
        push_service(4'b0001, 16'h0006, 16'h0000);
        req = 4'b0001;
        wait_writes(wb + 5, 20, "same_cycle_head");
        i = 0;
        while (!bus.tmr_irq && i < 50) begin
            tick();
            i++;
        end
        if (!bus.tmr_irq) timeout_fail("same_cycle_irq");
        req = 4'b0000;
        wait_done(db + 1, 20, "same_cycle_done");
        repeat (3) tick();

        // Reset during WAIT, then a full fresh service.
        period[63:32] = 32'd300;
        wb = wr_seen;
        push_head(4'b0010, 16'h012C, 16'h0000);
        req = 4'b0010;
        wait_writes(wb + 5, 20, "pre_reset_head");
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        wq.delete();
        dq.delete();
        period[63:32] = 32'd4;
        repeat (2) tick();
        db = done_seen;
        push_service(4'b0010, 16'h0004, 16'h0000);
        reset = 1'b0;
        wait_done(db + 1, 60, "post_reset");
        req = 4'b0000;
        repeat (4) tick();

        check("writes_outstanding", wq.size(), 32'd0);
        check("dones_outstanding", dq.size(), 32'd0);
        check("final_busy", {31'd0, busy}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
